// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and redirect controller for an in-order MIPS pipe.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   id_rs, id_rt           ID-stage source registers
//   id_j_b_stall           branch/jump operand not ready in ID
//   ld_rmem, ld_rt         per-shadow-stage load flag and load destination
//   mc_req, mc_done        per multicycle unit request (EX) and result-ready level
//   mc_start, mc_abort     per multicycle unit start pulse and cancel pulse
//   stallreq_from_if/mem   instruction / data bus busy
//   mem_excepttype         commit-stage exception code, 0 = none
//   mem_cp0_epc            return PC used for ERET
//   redirect_ready         fetch takes the redirect this cycle
//   redirect_valid/pc      pending redirect and its target
//   stall, flush           per-stage hold / bubble insert (0=IF, 1=ID, 2=EX, ...)

// One start/busy/done handshake FSM per multicycle unit.
// start/abort/mc_stall are decoded from the state in the same cycle, because the
// unit must be kicked in the very cycle EX presents its request.
module hazard_mc_fsm (
    input  logic clk,
    input  logic resetn,
    input  logic req,
    input  logic done,
    input  logic except,
    input  logic back_stall_other,
    output logic start,
    output logic abort,
    output logic mc_stall
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_t;
    mc_state_t state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (except) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (req)  state <= BUSY;
                BUSY:    if (done) state <= DONE;
                // Result is held until the rest of the back end can move, so
                // EX advances together with every other stalled unit.
                DONE:    if (!back_stall_other) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // DONE never goes straight back to BUSY: a held request must pass through
    // IDLE, i.e. a new instruction has to arrive in EX first.
    assign start    = (state == IDLE) && req && !except;
    assign abort    = except && (state != IDLE);
    assign mc_stall = ((state == IDLE) && req) || (state == BUSY);
endmodule

module hazard_ctrl #(
    parameter int          STAGES      = 5,
    parameter int          NUM_MC      = 2,
    parameter int          LOAD_SHADOW = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE   = 32'h0000000E
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [4:0]               id_rs,
    input  logic [4:0]               id_rt,
    input  logic                     id_j_b_stall,
    input  logic [LOAD_SHADOW-1:0]   ld_rmem,
    input  logic [5*LOAD_SHADOW-1:0] ld_rt,
    input  logic [NUM_MC-1:0]        mc_req,
    input  logic [NUM_MC-1:0]        mc_done,
    output logic [NUM_MC-1:0]        mc_start,
    output logic [NUM_MC-1:0]        mc_abort,
    input  logic                     stallreq_from_if,
    input  logic                     stallreq_from_mem,
    input  logic [31:0]              mem_excepttype,
    input  logic [31:0]              mem_cp0_epc,
    input  logic                     redirect_ready,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic [STAGES-1:0]        stall,
    output logic [STAGES-1:0]        flush
);
    logic                except;
    logic                lwstall;
    logic                mc_stall;
    logic                back_stall;
    logic                front_stall;
    logic [NUM_MC-1:0]   mc_stall_v;
    logic [NUM_MC-1:0]   back_stall_other;

    assign except = (mem_excepttype != 32'd0);

    // Load-use: any in-flight load whose destination feeds ID. $0 never hazards.
    always_comb begin
        lwstall = 1'b0;
        for (int k = 0; k < LOAD_SHADOW; k++) begin
            if (ld_rmem[k] && (ld_rt[5*k +: 5] != 5'd0) &&
                ((ld_rt[5*k +: 5] == id_rs) || (ld_rt[5*k +: 5] == id_rt)))
                lwstall = 1'b1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_MC; k++) begin : g_mc
            // A finished unit waits on data-bus stalls and on its siblings only.
            assign back_stall_other[k] = stallreq_from_mem |
                                         (|(mc_stall_v & ~(NUM_MC'(1) << k)));
            hazard_mc_fsm u_fsm (
                .clk              (clk),
                .resetn           (resetn),
                .req              (mc_req[k]),
                .done             (mc_done[k]),
                .except           (except),
                .back_stall_other (back_stall_other[k]),
                .start            (mc_start[k]),
                .abort            (mc_abort[k]),
                .mc_stall         (mc_stall_v[k])
            );
        end
    endgenerate

    assign mc_stall    = |mc_stall_v;
    assign back_stall  = mc_stall | stallreq_from_mem;
    assign front_stall = back_stall | lwstall | id_j_b_stall | stallreq_from_if;

    always_comb begin
        stall      = {STAGES{back_stall}};
        stall[1:0] = {2{front_stall}};
    end

    // Bubble into EX only when EX itself is free to take it; an exception
    // flushes everything and wins over stall in the stage registers.
    always_comb begin
        flush    = {STAGES{except}};
        flush[2] = flush[2] | ((lwstall | id_j_b_stall) & ~back_stall);
        flush[0] = flush[0] | redirect_valid;
    end

    // Redirect holding register: newest exception wins, cleared on handoff.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else if (except) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= (mem_excepttype == ERET_CODE) ? mem_cp0_epc : EXC_VECTOR;
        end else if (redirect_valid && redirect_ready) begin
            redirect_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, every cycle compared with a behavioural model of the control rules.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  id_rs, id_rt;
    logic        id_j_b_stall;
    logic [1:0]  ld_rmem;
    logic [9:0]  ld_rt;
    logic [1:0]  mc_req, mc_done, mc_start, mc_abort;
    logic        stallreq_from_if, stallreq_from_mem;
    logic [31:0] mem_excepttype, mem_cp0_epc;
    logic        redirect_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0]  stall, flush;

    int total = 0;
    int bad   = 0;

    // model state: unit computing, unit holding a finished result, redirect
    bit          m_busy [2];
    bit          m_hold [2];
    bit          m_rv;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk               (clk),
        .resetn            (resetn),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_j_b_stall      (id_j_b_stall),
        .ld_rmem           (ld_rmem),
        .ld_rt             (ld_rt),
        .mc_req            (mc_req),
        .mc_done           (mc_done),
        .mc_start          (mc_start),
        .mc_abort          (mc_abort),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_mem (stallreq_from_mem),
        .mem_excepttype    (mem_excepttype),
        .mem_cp0_epc       (mem_cp0_epc),
        .redirect_ready    (redirect_ready),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .stall             (stall),
        .flush             (flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_j_b_stall = 0; ld_rmem = 0; ld_rt = 0;
        mc_req = 0; mc_done = 0; stallreq_from_if = 0; stallreq_from_mem = 0;
        mem_excepttype = 0; mem_cp0_epc = 0; redirect_ready = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin m_busy[k] = 0; m_hold[k] = 0; end
        m_rv = 0; m_pc = 0;
    endtask

    // Check outputs mid-cycle against the model, then advance the model one clock.
    task automatic step(input string tag);
        bit exc, lw, back, front, other;
        logic [1:0] ms, est, eab;
        logic [4:0] es, ef;
        @(negedge clk);
        exc = (mem_excepttype != 0);
        lw = 0;
        for (int k = 0; k < 2; k++)
            if (ld_rmem[k] && ld_rt[5*k +: 5] != 0 &&
                (ld_rt[5*k +: 5] == id_rs || ld_rt[5*k +: 5] == id_rt)) lw = 1;
        for (int k = 0; k < 2; k++) begin
            ms[k]  = m_busy[k] || (!m_busy[k] && !m_hold[k] && mc_req[k]);
            est[k] = !m_busy[k] && !m_hold[k] && mc_req[k] && !exc;
            eab[k] = exc && (m_busy[k] || m_hold[k]);
        end
        back  = (ms != 0) || stallreq_from_mem;
        front = back || lw || id_j_b_stall || stallreq_from_if;
        es = {{3{back}}, {2{front}}};
        ef = {5{exc}};
        ef[2] = ef[2] | ((lw || id_j_b_stall) && !back);
        ef[0] = ef[0] | m_rv;
        chk({tag, ".stall"}, stall, es);
        chk({tag, ".flush"}, flush, ef);
        chk({tag, ".start"}, mc_start, est);
        chk({tag, ".abort"}, mc_abort, eab);
        chk({tag, ".rv"}, redirect_valid, m_rv);
        chk({tag, ".rpc"}, redirect_pc, m_pc);
        for (int k = 0; k < 2; k++) begin
            other = stallreq_from_mem;
            for (int j = 0; j < 2; j++) if (j != k && ms[j]) other = 1;
            if (exc) begin m_busy[k] = 0; m_hold[k] = 0; end
            else if (est[k]) m_busy[k] = 1;
            else if (m_busy[k] && mc_done[k]) begin m_busy[k] = 0; m_hold[k] = 1; end
            else if (m_hold[k] && !other) m_hold[k] = 0;
        end
        if (exc) begin
            m_rv = 1;
            m_pc = (mem_excepttype == 32'hE) ? mem_cp0_epc : 32'hBFC00380;
        end else if (m_rv && redirect_ready) m_rv = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        resetn = 0;
        #12;
        chk("reset.rv", redirect_valid, 0);
        chk("reset.rpc", redirect_pc, 0);
        chk("reset.stall", stall, 0);
        chk("reset.flush", flush, 0);
        #1 resetn = 1;
        @(posedge clk); #1;

        // load-use on stage 0 via rs, then a load to $0
        ld_rmem = 2'b01; ld_rt = 10'd5; id_rs = 5;
        #1 chk("lw.stall", stall, 5'b00011); chk("lw.flush", flush, 5'b00100);
        step("lw");
        ld_rt = 10'd0;
        #1 chk("lw0.stall", stall, 0); chk("lw0.flush", flush, 0);
        step("lw0");
        idle_inputs();

        // single divider, done in cycle 4
        for (int c = 0; c <= 6; c++) begin
            mc_req  = (c <= 5) ? 2'b01 : 2'b00;
            mc_done = (c == 4) ? 2'b01 : 2'b00;
            #1 chk("div.start", mc_start, (c == 0) ? 2'b01 : 2'b00);
            chk("div.stall", stall, (c <= 4) ? 5'b11111 : 5'b00000);
            step("div");
        end
        idle_inputs();

        // exception while divider busy
        mc_req = 2'b01; step("exc0");
        step("exc1");
        mem_excepttype = 1;
        #1 chk("exc.flush", flush, 5'b11111); chk("exc.abort", mc_abort, 2'b01);
        step("exc2");
        idle_inputs(); redirect_ready = 1;
        #1 chk("exc.rv", redirect_valid, 1); chk("exc.rpc", redirect_pc, 32'hBFC00380);
        chk("exc.restart", mc_start, 0);
        step("exc3");
        redirect_ready = 0;
        step("exc4");

        // ERET with a slow fetch
        mem_excepttype = 32'hE; mem_cp0_epc = 32'h80001234;
        step("eret0");
        idle_inputs();
        for (int c = 1; c <= 5; c++) begin
            redirect_ready = (c == 4);
            #1 chk("eret.rv", redirect_valid, (c <= 4) ? 1 : 0);
            chk("eret.flush0", flush[0], (c <= 4) ? 1 : 0);
            if (c <= 4) chk("eret.rpc", redirect_pc, 32'h80001234);
            step("eret");
        end
        idle_inputs();

        // two units, unit1 finishes first, data bus busy
        for (int c = 0; c <= 7; c++) begin
            mc_req  = (c <= 6) ? 2'b11 : 2'b00;
            mc_done = {(c >= 2 && c <= 6), (c >= 4 && c <= 6)};
            stallreq_from_mem = (c >= 1 && c <= 5);
            #1 chk("dual.stall", stall, (c <= 5) ? 5'b11111 : 5'b00000);
            chk("dual.start", mc_start, (c == 0) ? 2'b11 : 2'b00);
            step("dual");
        end
        idle_inputs();

        // async reset mid-BUSY with a redirect pending
        mem_excepttype = 3; step("rst0");
        idle_inputs(); mc_req = 2'b01; step("rst1");
        #1 resetn = 0;
        #1 chk("rst.rv", redirect_valid, 0); chk("rst.rpc", redirect_pc, 0);
        mc_req = 0;
        #1 chk("rst.stall", stall, 0); chk("rst.start", mc_start, 0);
        model_reset();
        @(posedge clk); #2 resetn = 1;
        #1 chk("rst.norel", mc_start, 0);
        step("rst2");
        mc_req = 2'b01;
        step("rst3");
        idle_inputs();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ld_rmem = 2'($urandom);
            ld_rt = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_j_b_stall = ($urandom_range(0, 7) == 0);
            mc_req = 2'($urandom);
            mc_done = 2'($urandom);
            stallreq_from_if = ($urandom_range(0, 5) == 0);
            stallreq_from_mem = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 19);
            mem_excepttype = (r == 0) ? 32'h1 : (r == 1) ? 32'hE : (r == 2) ? $urandom : 32'h0;
            mem_cp0_epc = $urandom;
            redirect_ready = $urandom_range(0, 1);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
